// File: rtl/switch_event_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// switch_evt_pkg
// Shared types and helpers for switch_event_scheduler and its arbiter.
//   EVT_PRESS / EVT_REL : event type encoding driven on o_evt_rel
//   state_e             : offer FSM states (ST_IDLE, ST_OFFER)
//   rr_next()           : round-robin pointer advance with wrap at n-1 -> 0
// ---------------------------------------------------------------------------
package switch_evt_pkg;

   localparam logic EVT_PRESS = 1'b0;
   localparam logic EVT_REL   = 1'b1;

   typedef enum logic {
      ST_IDLE,
      ST_OFFER
   } state_e;

   function automatic int unsigned rr_next(input int unsigned idx,
                                           input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/switch_event_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts at ptr_i and wraps
// from N-1 back to 0; the first set request found wins.
// Ports:
//   req_i     [N-1:0] request lines
//   ptr_i     [W-1:0] highest-priority line for this search
//   gnt_o     [N-1:0] one-hot grant (all zero when no request)
//   gnt_idx_o [W-1:0] index of the granted line
//   any_req_o         at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int unsigned N = 4,
   parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] gnt_idx_o,
   output logic         any_req_o
);

   logic           found;
   int unsigned    j;
   logic [W-1:0]   jw;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      j         = 0;
      jw        = '0;
      for (int unsigned i = 0; i < N; i++) begin
         j = 32'(ptr_i) + i;
         if (j >= N) j = j - N;
         jw = W'(j);
         if (!found && req_i[jw]) begin
            found         = 1'b1;
            gnt_o[jw]     = 1'b1;
            gnt_idx_o     = jw;
         end
      end
   end

   assign any_req_o = |req_i;

endmodule

// File: rtl/switch_event_scheduler.sv
// ---------------------------------------------------------------------------
// switch_event_scheduler
// Turns debounced switch level changes into discrete events, latches one
// pending event per switch (and type), and serialises them onto a single
// valid/ready event port through a round-robin arbiter.
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   i_sw         [N_SW-1:0] debounced switch levels, 1 = pressed
//   o_evt_valid  event offered
//   i_evt_ready  consumer accepts (transfer on valid && ready)
//   o_evt_idx    [IDX_W-1:0] switch index of the offered event
//   o_evt_rel    0 = press, 1 = release
//   o_overrun    sticky: an edge arrived while the same event was pending
// Build option:
//   SWITCH_EVENT_SCHEDULER_RELEASE_EVT_EN - also report falling edges as
//   release events (lines interleaved press0, rel0, press1, rel1, ...).
//   Undefined: press events only, o_evt_rel tied to 0.
// ---------------------------------------------------------------------------
module switch_event_scheduler
   import switch_evt_pkg::*;
#(
   parameter int unsigned N_SW  = 4,
   parameter int unsigned IDX_W = $clog2(N_SW)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SW-1:0]  i_sw,
   output logic             o_evt_valid,
   input  logic             i_evt_ready,
   output logic [IDX_W-1:0] o_evt_idx,
   output logic             o_evt_rel,
   output logic             o_overrun
);

`ifdef SWITCH_EVENT_SCHEDULER_RELEASE_EVT_EN
   localparam int unsigned N_LN = 2 * N_SW;
`else
   localparam int unsigned N_LN = N_SW;
`endif
   localparam int unsigned LN_W = $clog2(N_LN);

   logic [N_SW-1:0]  prev_q;
   logic [N_SW-1:0]  press_q, press_d;
   logic [N_SW-1:0]  rise;
   logic [N_SW-1:0]  clr_press;

   logic [N_LN-1:0]  req;
   logic [N_LN-1:0]  gnt;
   logic [N_LN-1:0]  win_oh_q;
   logic [N_LN-1:0]  clr_ln;
   logic [LN_W-1:0]  gnt_idx;
   logic [LN_W-1:0]  win_q;
   logic [LN_W-1:0]  ptr_q, ptr_d;
   logic             any_req;

   state_e           state_q;
   logic             valid_q;
   logic [IDX_W-1:0] idx_q;
   logic             ovr_q, ovr_d;
   logic             accept;
   logic             take;

   assign rise   = i_sw & ~prev_q;
   assign accept = valid_q & i_evt_ready;
   // A new winner is picked only from idle or at the moment of transfer.
   assign take   = (state_q == ST_IDLE) | accept;
   assign clr_ln = accept ? win_oh_q : '0;
   assign ptr_d  = accept ? LN_W'(rr_next(32'(win_q), N_LN)) : ptr_q;

`ifdef SWITCH_EVENT_SCHEDULER_RELEASE_EVT_EN
   logic [N_SW-1:0] rel_q, rel_d;
   logic [N_SW-1:0] fall;
   logic [N_SW-1:0] clr_rel;
   logic            evt_rel_q;

   assign fall = ~i_sw & prev_q;

   // Release request is held off while the press of the same switch is
   // pending so the press is always delivered first.
   for (genvar k = 0; k < N_SW; k++) begin : g_lines
      assign clr_press[k]  = clr_ln[2*k];
      assign clr_rel[k]    = clr_ln[2*k+1];
      assign req[2*k]      = press_d[k];
      assign req[2*k+1]    = rel_d[k] & ~press_d[k];
   end
`else
   assign clr_press = clr_ln;
   assign req       = press_d;
`endif

   // Next pending state: a new edge overrides the clear of the accepted line;
   // an edge on a line that stays pending is dropped and flagged.
   always_comb begin
      press_d = (press_q & ~clr_press) | rise;
      ovr_d   = ovr_q | (|(rise & press_q & ~clr_press));
`ifdef SWITCH_EVENT_SCHEDULER_RELEASE_EVT_EN
      rel_d   = (rel_q & ~clr_rel) | fall;
      ovr_d   = ovr_d | (|(fall & rel_q & ~clr_rel));
`endif
   end

   // Arbitrate over next-cycle pending state so a fresh edge is offered on
   // the same edge that latches it.
   rr_arbiter #(
      .N (N_LN),
      .W (LN_W)
   ) u_arb (
      .req_i     (req),
      .ptr_i     (ptr_d),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_req_o (any_req)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q    <= i_sw;
         press_q   <= '0;
         ptr_q     <= '0;
         ovr_q     <= 1'b0;
         state_q   <= ST_IDLE;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         win_q     <= '0;
         win_oh_q  <= '0;
`ifdef SWITCH_EVENT_SCHEDULER_RELEASE_EVT_EN
         rel_q     <= '0;
         evt_rel_q <= EVT_PRESS;
`endif
      end else begin
         prev_q  <= i_sw;
         press_q <= press_d;
         ptr_q   <= ptr_d;
         ovr_q   <= ovr_d;
`ifdef SWITCH_EVENT_SCHEDULER_RELEASE_EVT_EN
         rel_q   <= rel_d;
`endif
         if (take) begin
            if (any_req) begin
               state_q  <= ST_OFFER;
               valid_q  <= 1'b1;
               win_q    <= gnt_idx;
               win_oh_q <= gnt;
`ifdef SWITCH_EVENT_SCHEDULER_RELEASE_EVT_EN
               idx_q     <= IDX_W'(gnt_idx >> 1);
               evt_rel_q <= gnt_idx[0] ? EVT_REL : EVT_PRESS;
`else
               idx_q     <= IDX_W'(gnt_idx);
`endif
            end else begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end
         end
      end
   end

   assign o_evt_valid = valid_q;
   assign o_evt_idx   = idx_q;
   assign o_overrun   = ovr_q;
`ifdef SWITCH_EVENT_SCHEDULER_RELEASE_EVT_EN
   assign o_evt_rel   = evt_rel_q;
`else
   assign o_evt_rel   = EVT_PRESS;
`endif

endmodule
